age_lru_unit: RTL and testbench
===============================

AGE_LRU_UNIT -- requirements
Module: age_lru_unit

Interface
REQ-001 SHALL have parameter SET_ADDR_WDTH, default 5, meaning set address width; the unit holds 1<<SET_ADDR_WDTH sets.
REQ-002 SHALL have parameter C_N_WAY, default 3, meaning log2 of way count; the unit holds 1<<C_N_WAY ways per set, each way with a C_N_WAY-bit age.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid_in, input, 1 bit: request present.
REQ-006 SHALL have port req_ready_out, output, 1 bit: request accepted when high together with req_valid_in.
REQ-007 SHALL have port req_op_in, input, 1 bit: 0 = lookup, 1 = touch.
REQ-008 SHALL have port req_set_in, input, SET_ADDR_WDTH bits: target set.
REQ-009 SHALL have port req_way_in, input, C_N_WAY bits: way to promote; used by touch only.
REQ-010 SHALL have port rsp_valid_out, output, 1 bit: response strobe.
REQ-011 SHALL have port rsp_ages_out, output, (1<<C_N_WAY)*C_N_WAY bits: age vector, way 0 in the LSBs.
REQ-012 SHALL have port rsp_victim_out, output, C_N_WAY bits: least-recently-used way.
REQ-013 SHALL have port init_busy_out, output, 1 bit: clear sweep in progress.

Function
REQ-014 SHALL have two states: STATE_CLEAR, entered on reset, and STATE_NORMAL.
REQ-015 In STATE_CLEAR, SHALL write the identity vector (way w gets age w) to one set per cycle, starting at set 0, using an incrementing counter.
REQ-016 SHALL move to STATE_NORMAL in the cycle after the write to set (1<<SET_ADDR_WDTH)-1, giving a sweep of exactly 1<<SET_ADDR_WDTH cycles.
REQ-017 SHALL drive init_busy_out high in STATE_CLEAR and low in STATE_NORMAL.
REQ-018 SHALL drive req_ready_out as (state == STATE_NORMAL); there is no other backpressure, so one request per cycle is sustained.
REQ-019 Storage SHALL be one memory with one synchronous read port and one write port; the read is registered in pipeline stage S1.
REQ-020 Results SHALL be computed in stage S2; rsp_valid_out SHALL rise exactly 2 cycles after the acceptance edge.
REQ-021 Responses SHALL be returned in request order.
REQ-022 Lookup SHALL return the stored ages and the victim, with no memory write.
REQ-023 Touch SHALL form new ages from old age a = age[way]:
- age[way] becomes 0;
- every age[i] < a becomes age[i]+1;
- all other ages are unchanged.
REQ-024 Touch SHALL write the new vector to the memory in S2 and return the new vector and its victim.
REQ-025 Victim SHALL be the lowest-index way whose age equals (1<<C_N_WAY)-1; if no way has that age, victim SHALL be 0.
REQ-026 Forwarding: when S1 holds the same set as a touch being written in S2, the S2 write data SHALL replace the S1 read data.
REQ-027 Forwarding: when a touch write and a new read of the same set occur in the same cycle, the read SHALL return the new data (write-first).
REQ-028 As a result of REQ-026/REQ-027, back-to-back requests to one set SHALL always see every earlier touch.
REQ-029 Touching a way whose age is already 0 SHALL leave the vector unchanged; the write still occurs.
REQ-030 Age arithmetic SHALL be C_N_WAY bits, unsigned; no increment can overflow, because only ages below a, where a ≤ (1<<C_N_WAY)-1, are incremented.
REQ-031 Requests presented while req_ready_out is low SHALL be ignored and produce no response.

Reset
REQ-032 Reset asserted SHALL immediately force:
- state = STATE_CLEAR, sweep counter = 0;
- S1/S2 valid flags = 0;
- rsp_valid_out = 0, rsp_ages_out = 0, rsp_victim_out = 0;
- req_ready_out = 0, init_busy_out = 1.
REQ-033 Memory contents SHALL NOT be reset; they are overwritten by the sweep.
REQ-034 Reset asserted mid-sweep or mid-pipeline SHALL discard all in-flight requests; the sweep SHALL restart from set 0 after deassertion.

Verification (C_N_WAY=3, SET_ADDR_WDTH=5)
REQ-035 Release reset -> init_busy_out high for exactly 32 cycles; then lookup set 5 -> ages way0..7 = 0..7, victim 7, response 2 cycles after acceptance.
REQ-036 After init, touch set 3 way 7 -> rsp ages = way7 0, way0..6 = 1..7, victim 6; a later lookup of set 3 returns the same vector.
REQ-037 Touch set 3 way 7, then touch set 3 way 2, then lookup set 3, on consecutive cycles -> final ages way0..7 = 2,3,0,4,5,6,7,1, victim 6, proving forwarding.
REQ-038 Touch set 9 way 0 (age 0) -> vector unchanged (0..7), victim 7.
REQ-039 Assert reset with two requests in flight and the sweep previously done -> rsp_valid_out 0 with no late response; after release, a lookup of any set (0, 31) returns identity.
REQ-040 Requests held valid throughout the sweep -> no response until req_ready_out rises; the first accepted request responds 2 cycles later.

Source files
------------

// File: rtl/age_lru_unit.sv
// age_lru_unit: per-set age-based LRU tracker with a power-on clear sweep and a
// two-stage lookup/touch pipeline (S1 registered read, S2 age update and write-back).
`default_nettype none

module age_lru_unit #(
    parameter int SET_ADDR_WDTH = 5,
    parameter int C_N_WAY       = 3
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 req_valid_in,
    output logic                                 req_ready_out,
    input  logic                                 req_op_in,
    input  logic [SET_ADDR_WDTH-1:0]             req_set_in,
    input  logic [C_N_WAY-1:0]                   req_way_in,
    output logic                                 rsp_valid_out,
    output logic [(1<<C_N_WAY)*C_N_WAY-1:0]      rsp_ages_out,
    output logic [C_N_WAY-1:0]                   rsp_victim_out,
    output logic                                 init_busy_out
);

    localparam int N_WAYS = 1 << C_N_WAY;
    localparam int AGES_W = N_WAYS * C_N_WAY;
    localparam int N_SETS = 1 << SET_ADDR_WDTH;

    typedef enum logic [0:0] {
        STATE_CLEAR  = 1'b0,
        STATE_NORMAL = 1'b1
    } state_t;

    state_t                    state, next_state;
    logic [SET_ADDR_WDTH-1:0]  sweep_cnt;

    logic [AGES_W-1:0]         mem [N_SETS];

    logic                      s1_valid, s1_op;
    logic [SET_ADDR_WDTH-1:0]  s1_set;
    logic [C_N_WAY-1:0]        s1_way;
    logic [AGES_W-1:0]         s1_data;

    logic                      s2_valid, s2_op;
    logic [SET_ADDR_WDTH-1:0]  s2_set;
    logic [C_N_WAY-1:0]        s2_way;
    logic [AGES_W-1:0]         s2_data;

    logic [AGES_W-1:0]         identity;
    logic [AGES_W-1:0]         new_ages;
    logic [C_N_WAY-1:0]        old_age;
    logic [C_N_WAY-1:0]        victim;
    logic                      found;

    logic                      wr_en;
    logic [SET_ADDR_WDTH-1:0]  wr_set;
    logic [AGES_W-1:0]         wr_data;
    logic                      accept;

    assign req_ready_out = (state == STATE_NORMAL);
    assign init_busy_out = (state == STATE_CLEAR);
    assign accept        = req_valid_in && req_ready_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= STATE_CLEAR;
            sweep_cnt <= '0;
        end else begin
            state <= next_state;
            if (state == STATE_CLEAR)
                sweep_cnt <= sweep_cnt + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        if (state == STATE_CLEAR && sweep_cnt == {SET_ADDR_WDTH{1'b1}})
            next_state = STATE_NORMAL;
    end

    always_comb begin
        identity = '0;
        for (int w = 0; w < N_WAYS; w++)
            identity[w*C_N_WAY +: C_N_WAY] = C_N_WAY'(w);
    end

    // S2: promote the touched way; only ages younger than it move up by one.
    always_comb begin
        old_age  = s2_data[s2_way*C_N_WAY +: C_N_WAY];
        new_ages = s2_data;
        if (s2_op) begin
            for (int i = 0; i < N_WAYS; i++) begin
                if (C_N_WAY'(i) == s2_way)
                    new_ages[i*C_N_WAY +: C_N_WAY] = '0;
                else if (s2_data[i*C_N_WAY +: C_N_WAY] < old_age)
                    new_ages[i*C_N_WAY +: C_N_WAY] = s2_data[i*C_N_WAY +: C_N_WAY] + 1'b1;
            end
        end
        victim = '0;
        found  = 1'b0;
        for (int i = 0; i < N_WAYS; i++) begin
            if (!found && new_ages[i*C_N_WAY +: C_N_WAY] == {C_N_WAY{1'b1}}) begin
                victim = C_N_WAY'(i);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        wr_en   = s2_valid && s2_op;
        wr_set  = s2_set;
        wr_data = new_ages;
        if (state == STATE_CLEAR) begin
            wr_en   = 1'b1;
            wr_set  = sweep_cnt;
            wr_data = identity;
        end
    end

    // Storage and pipeline data carry no reset; the sweep rewrites every set.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_set] <= wr_data;
        s1_data <= (wr_en && wr_set == req_set_in) ? wr_data : mem[req_set_in];
        s1_op   <= req_op_in;
        s1_set  <= req_set_in;
        s1_way  <= req_way_in;
        s2_data <= (wr_en && s2_set == s1_set) ? new_ages : s1_data;
        s2_op   <= s1_op;
        s2_set  <= s1_set;
        s2_way  <= s1_way;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid       <= 1'b0;
            s2_valid       <= 1'b0;
            rsp_valid_out  <= 1'b0;
            rsp_ages_out   <= '0;
            rsp_victim_out <= '0;
        end else begin
            s1_valid      <= accept;
            s2_valid      <= s1_valid;
            rsp_valid_out <= s2_valid;
            if (s2_valid) begin
                rsp_ages_out   <= new_ages;
                rsp_victim_out <= victim;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_age_lru_unit.sv
// Scoreboard bench for age_lru_unit: directed requests push expected responses,
// an independent monitor pops and compares each response including its latency.
`default_nettype none

module tb_age_lru_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid_in;
    logic        req_ready_out;
    logic        req_op_in;
    logic [4:0]  req_set_in;
    logic [2:0]  req_way_in;
    logic        rsp_valid_out;
    logic [23:0] rsp_ages_out;
    logic [2:0]  rsp_victim_out;
    logic        init_busy_out;

    typedef struct {
        logic [23:0] ages;
        logic [2:0]  vic;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    age_lru_unit #(.SET_ADDR_WDTH(5), .C_N_WAY(3)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid_in   (req_valid_in),
        .req_ready_out  (req_ready_out),
        .req_op_in      (req_op_in),
        .req_set_in     (req_set_in),
        .req_way_in     (req_way_in),
        .rsp_valid_out  (rsp_valid_out),
        .rsp_ages_out   (rsp_ages_out),
        .rsp_victim_out (rsp_victim_out),
        .init_busy_out  (init_busy_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] pk(input int a0, input int a1, input int a2, input int a3,
                                       input int a4, input int a5, input int a6, input int a7);
        logic [23:0] r;
        r = {3'(a7), 3'(a6), 3'(a5), 3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; drives one request for one cycle and returns at the next negedge.
    task automatic issue(input logic op, input int set, input int way,
                         input logic [23:0] ea, input logic [2:0] ev);
        logic rdy;
        req_valid_in = 1'b1;
        req_op_in    = op;
        req_set_in   = 5'(set);
        req_way_in   = 3'(way);
        rdy          = req_ready_out;
        chk("issue_ready", {31'd0, rdy}, 32'd1);
        @(posedge clk);
        #1;
        if (rdy) sb.push_back('{ages: ea, vic: ev, due: cyc + 2});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req_valid_in = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain;
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    task automatic count_sweep(input string name);
        int n = 0;
        while (init_busy_out && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk(name, 32'(n), 32'd32);
        chk("ready_after_sweep", {31'd0, req_ready_out}, 32'd1);
    endtask

    // Monitor: every response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rsp_valid_out) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got ages %h victim %0d expected no response",
                         rsp_ages_out, rsp_victim_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_ages", {8'd0, rsp_ages_out}, {8'd0, e.ages});
                chk("rsp_victim", {29'd0, rsp_victim_out}, {29'd0, e.vic});
                chk("rsp_latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    logic [23:0] ident, a_vec, b_vec;

    initial begin
        ident = pk(0, 1, 2, 3, 4, 5, 6, 7);
        a_vec = pk(1, 2, 3, 4, 5, 6, 7, 0);
        b_vec = pk(2, 3, 0, 4, 5, 6, 7, 1);

        reset        = 1'b0;
        req_valid_in = 1'b0;
        req_op_in    = 1'b0;
        req_set_in   = '0;
        req_way_in   = '0;
        #2;
        chk("rst_ready", {31'd0, req_ready_out}, 32'd0);
        chk("rst_busy", {31'd0, init_busy_out}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid_out}, 32'd0);
        chk("rst_ages", {8'd0, rsp_ages_out}, 32'd0);
        chk("rst_victim", {29'd0, rsp_victim_out}, 32'd0);

        repeat (2) @(negedge clk);
        reset = 1'b1;
        count_sweep("busy_cycles");

        issue(1'b0, 5, 0, ident, 3'd7);
        idle(3);

        // Back-to-back touches and lookup of one set exercise both forwarding paths.
        issue(1'b1, 3, 7, a_vec, 3'd6);
        issue(1'b1, 3, 2, b_vec, 3'd6);
        issue(1'b0, 3, 0, b_vec, 3'd6);
        idle(1);

        issue(1'b1, 9, 0, ident, 3'd7);
        idle(1);
        drain();

        // Reset with two requests in flight; their responses must never appear.
        issue(1'b1, 3, 7, a_vec, 3'd6);
        issue(1'b0, 0, 0, ident, 3'd7);
        reset = 1'b0;
        sb.delete();
        req_valid_in = 1'b1;
        req_op_in    = 1'b0;
        req_set_in   = 5'd0;
        #1;
        chk("mid_rst_rsp_valid", {31'd0, rsp_valid_out}, 32'd0);
        chk("mid_rst_ready", {31'd0, req_ready_out}, 32'd0);
        chk("mid_rst_busy", {31'd0, init_busy_out}, 32'd1);
        chk("mid_rst_ages", {8'd0, rsp_ages_out}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        count_sweep("busy_cycles_again");

        issue(1'b0, 0, 0, ident, 3'd7);
        issue(1'b0, 31, 0, ident, 3'd7);
        issue(1'b1, 3, 7, a_vec, 3'd6);
        idle(4);
        issue(1'b0, 3, 0, a_vec, 3'd6);
        idle(1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
